reaction_timer_multi: RTL and testbench
=======================================

Name: reaction_timer_multi

Overview:
- Parametrised multi-player successor of the single-player reaction timer.
- Replaces the incrementing random seed with an LFSR-drawn delay in milliseconds.
- Adds 1..4 independent stop inputs, per-player BCD result capture and outcome codes, a configurable timeout, and a winner index.
- Adds a best-time record that persists across rounds; feeds the seven-seg/OLED display path.

Parameters:
- DVSR, 100000: clocks per 1 ms tick; prescaler counts 0..DVSR-1.
- N_PLAYERS, 2: number of stop inputs/channels, legal 1..4.
- MIN_DELAY_MS, 2000: minimum random delay before stimulus, ms.
- DELAY_RANGE_LOG2, 13: random extra delay is 0..2^DELAY_RANGE_LOG2-1 ms; must be 1..15.
- TIMEOUT_MS, 1000: reaction window, ms; legal 1..9999.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  begin round; acted on in IDLE or DONE only.
- i_stop  in  N_PLAYERS  per-player stop; the first high cycle is taken, later highs are ignored.
- o_stimulus  out  1  high only in REACT.
- o_state  out  2  IDLE=0, WAIT=1, REACT=2, DONE=3.
- o_time  out  16*N_PLAYERS  per-player 4-digit BCD ms, player p at [16p+15:16p], digit3 most significant.
- o_result  out  2*N_PLAYERS  per player: 0 pending, 1 ok, 2 early, 3 late.
- o_winner  out  2  index of fastest ok player.
- o_winner_valid  out  1  at least one ok player in the finished round.
- o_best_time  out  16  best ok time since reset, BCD.
- o_live_time  out  16  running BCD counter, for display.

Behaviour:
- Reset (i_reset_n low, async):
  - state IDLE; all o_time 0x0000; all o_result 0; o_winner 0; o_winner_valid 0; o_best_time 0x9999; o_live_time 0x0000; o_stimulus 0; prescaler 0; LFSR 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every clock in every state and never reaches zero.
- IDLE, or DONE, with i_start=1:
  - latch delay_ms = MIN_DELAY_MS + (lfsr & (2^DELAY_RANGE_LOG2-1));
  - clear live time, prescaler, all results/times and o_winner_valid; go to WAIT next cycle.
- WAIT:
  - delay down-counter decrements on each ms tick.
  - Any i_stop[p] with result 0: result=2, time=0x9999.
  - If every player is early, go to DONE.
  - Else when the delay counter is 0 at a tick, go to REACT with live time 0x0000 and prescaler 0.
- REACT:
  - BCD live counter increments per tick, digit carry 9->0; no overflow is possible because TIMEOUT_MS ≤ 9999.
  - i_stop[p] with result 0: result=1, time=live value in that cycle.
  - Same-cycle stops from several players capture identical times.
  - When live time == TIMEOUT_MS (BCD compare), all pending players get result=3, time=TIMEOUT_MS BCD.
  - A stop in the same cycle as the timeout counts as ok, not late.
  - Go to DONE when no player is pending.
- Entry to DONE, registered one cycle after the last result is set:
  - o_winner = lowest index among minimum ok times; o_winner_valid=1 if any ok.
  - o_best_time updated if winner time < o_best_time.
  - All values hold until the next i_start.
- i_stop in IDLE/DONE ignored. i_start in WAIT/REACT ignored.
- A player's result, once non-zero, is frozen for the round.
- Unused high o_winner bits are 0 when N_PLAYERS<4.

Decomposition:
- Shared package holds:
  - state encodings IDLE/WAIT/REACT/DONE;
  - result codes RES_PENDING/OK/EARLY/LATE;
  - LFSR seed and tap constants;
  - BCD_MAX 16'h9999.
- One natural sub-module, bcd_ms_counter: prescaler plus 4-digit BCD up-counter with clear, enable, tick output and live value.
- The FSM, capture, winner and best-time logic stay in the top.

Test Plan:
- Run all scenarios with DVSR=4, MIN_DELAY_MS=3, DELAY_RANGE_LOG2=2, TIMEOUT_MS=20, N_PLAYERS=2.
- Reset low mid-REACT -> next cycle state 0, stimulus 0, o_best_time 0x9999, all results 0.
- Start, P0 stops at live 0x0007, P1 at 0x0012 -> results 1/1, times 0x0007/0x0012, winner 0, valid 1, best 0x0007.
- Start, P1 presses in WAIT, P0 stops at 0x0005 -> P1 result 2 time 0x9999, winner 0, best updated to 0x0005.
- Start, no stops -> at live 0x0020 both result 3, time 0x0020, valid 0, best unchanged.
- Start, both press in WAIT -> DONE without stimulus ever going high, both results 2, valid 0.
- Both stop in the same cycle at 0x0009 -> equal times, winner 0; a later i_stop in DONE leaves all results and times unchanged.

Source files
------------

// File: rtl/reaction_timer_multi_pkg.sv
// reaction_timer_multi_pkg: shared state/result encodings, LFSR constants and BCD helpers
package reaction_timer_multi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, REACT = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {RES_PENDING = 2'd0, RES_OK = 2'd1, RES_EARLY = 2'd2, RES_LATE = 2'd3} result_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 of a right-shifting Fibonacci register sit at bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] BCD_MAX = 16'h9999;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++)
      if (c) begin
        if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
        else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction
endpackage

// File: rtl/reaction_timer_multi_if.sv
// reaction_timer_multi_if: player/display bus; master drives i_start/i_stop, slave (the timer) drives all o_* results
interface reaction_timer_multi_if #(parameter int N_PLAYERS = 2);
  logic                   i_start;
  logic [N_PLAYERS-1:0]   i_stop;
  logic                   o_stimulus;
  logic [1:0]             o_state;
  logic [16*N_PLAYERS-1:0] o_time;
  logic [2*N_PLAYERS-1:0] o_result;
  logic [1:0]             o_winner;
  logic                   o_winner_valid;
  logic [15:0]            o_best_time;
  logic [15:0]            o_live_time;
  modport master (output i_start, i_stop,
                  input o_stimulus, o_state, o_time, o_result, o_winner, o_winner_valid, o_best_time, o_live_time);
  modport slave (input i_start, i_stop,
                 output o_stimulus, o_state, o_time, o_result, o_winner, o_winner_valid, o_best_time, o_live_time);
endinterface

// File: rtl/reaction_timer_multi_bcd_ms_counter.sv
// reaction_timer_multi_bcd_ms_counter: ms prescaler plus 4-digit BCD up-counter
// ports: i_clk, i_reset_n (async low), i_clr (zero prescaler and count), i_en (count ms ticks), o_tick (last clock of each ms), o_live (BCD ms)
module reaction_timer_multi_bcd_ms_counter
  import reaction_timer_multi_pkg::*;
#(
  parameter int DVSR = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clr,
  input  logic        i_en,
  output logic        o_tick,
  output logic [15:0] o_live
);
  localparam int PW = DVSR > 1 ? $clog2(DVSR) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] live_q, live_d;
  assign o_tick = pre_q == PW'(DVSR - 1);
  assign o_live = live_q;
  always_comb begin
    pre_d = (i_clr || o_tick) ? '0 : pre_q + 1'b1;
    live_d = i_clr ? '0 : (i_en && o_tick) ? bcd_inc(live_q) : live_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      pre_q <= '0;
      live_q <= '0;
    end else begin
      pre_q <= pre_d;
      live_q <= live_d;
    end
endmodule

// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi: multi-player reaction timer with random delay, timeout, winner and best-time record
// ports: i_clk, i_reset_n (async low), bus (slave: i_start/i_stop in; stimulus, state, per-player times/results, winner, best and live time out)
module reaction_timer_multi
  import reaction_timer_multi_pkg::*;
#(
  parameter int DVSR             = 100000,
  parameter int N_PLAYERS        = 2,
  parameter int MIN_DELAY_MS     = 2000,
  parameter int DELAY_RANGE_LOG2 = 13,
  parameter int TIMEOUT_MS       = 1000
) (
  input logic i_clk,
  input logic i_reset_n,
  reaction_timer_multi_if.slave bus
);
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << DELAY_RANGE_LOG2)) + 1;
  localparam logic [15:0] MASK = 16'((1 << DELAY_RANGE_LOG2) - 1);
  localparam logic [15:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [DW-1:0] delay_q, delay_d;
  result_t res_q [N_PLAYERS];
  result_t res_d [N_PLAYERS];
  logic [15:0] time_q [N_PLAYERS];
  logic [15:0] time_d [N_PLAYERS];
  logic [1:0] winner_q, winner_d;
  logic valid_q, valid_d;
  logic [15:0] best_q, best_d;
  logic stim_q, stim_d;
  logic fin_q, fin_d;
  logic clr, tick, all_early, any_pend, win_found;
  logic [1:0] win_idx;
  logic [15:0] win_time, live;
  reaction_timer_multi_bcd_ms_counter #(.DVSR(DVSR)) u_cnt (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_clr(clr),
    .i_en(state_q == REACT),
    .o_tick(tick),
    .o_live(live)
  );
  // fastest ok player from the frozen results; strict compare keeps the lowest index on ties
  always_comb begin
    win_found = 1'b0;
    win_idx = 2'd0;
    win_time = BCD_MAX;
    for (int p = 0; p < N_PLAYERS; p++)
      if (res_q[p] == RES_OK && (!win_found || time_q[p] < win_time)) begin
        win_found = 1'b1;
        win_idx = 2'(p);
        win_time = time_q[p];
      end
  end
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_next(lfsr_q);
    delay_d = delay_q;
    res_d = res_q;
    time_d = time_q;
    winner_d = winner_q;
    valid_d = valid_q;
    best_d = best_q;
    clr = 1'b0;
    all_early = 1'b1;
    any_pend = 1'b0;
    // fin_q marks the first DONE cycle, so the winner sees the registered final results
    if (fin_q) begin
      winner_d = win_idx;
      valid_d = win_found;
      if (win_found && win_time < best_q) best_d = win_time;
    end
    case (state_q)
      WAIT: begin
        if (tick && delay_q != '0) delay_d = delay_q - 1'b1;
        for (int p = 0; p < N_PLAYERS; p++) begin
          if (bus.i_stop[p] && res_q[p] == RES_PENDING) begin
            res_d[p] = RES_EARLY;
            time_d[p] = BCD_MAX;
          end
          all_early = all_early & (res_d[p] == RES_EARLY);
        end
        if (all_early) state_d = DONE;
        else if (tick && delay_q == '0) begin
          state_d = REACT;
          clr = 1'b1;
        end
      end
      REACT: begin
        // a stop beats the timeout when both land in the same cycle
        for (int p = 0; p < N_PLAYERS; p++) begin
          if (res_q[p] == RES_PENDING) begin
            if (bus.i_stop[p]) begin
              res_d[p] = RES_OK;
              time_d[p] = live;
            end else if (live == TIMEOUT_BCD) begin
              res_d[p] = RES_LATE;
              time_d[p] = TIMEOUT_BCD;
            end
          end
          any_pend = any_pend | (res_d[p] == RES_PENDING);
        end
        if (!any_pend) state_d = DONE;
      end
      default: if (bus.i_start) begin
        delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr_q & MASK);
        clr = 1'b1;
        for (int p = 0; p < N_PLAYERS; p++) begin
          res_d[p] = RES_PENDING;
          time_d[p] = '0;
        end
        valid_d = 1'b0;
        state_d = WAIT;
      end
    endcase
    stim_d = state_d == REACT;
    fin_d = state_q != DONE && state_d == DONE;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      delay_q <= '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        res_q[p] <= RES_PENDING;
        time_q[p] <= '0;
      end
      winner_q <= 2'd0;
      valid_q <= 1'b0;
      best_q <= BCD_MAX;
      stim_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      delay_q <= delay_d;
      res_q <= res_d;
      time_q <= time_d;
      winner_q <= winner_d;
      valid_q <= valid_d;
      best_q <= best_d;
      stim_q <= stim_d;
      fin_q <= fin_d;
    end
  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_out
    assign bus.o_time[16*g +: 16] = time_q[g];
    assign bus.o_result[2*g +: 2] = res_q[g];
  end
  assign bus.o_stimulus = stim_q;
  assign bus.o_state = state_q;
  assign bus.o_winner = winner_q;
  assign bus.o_winner_valid = valid_q;
  assign bus.o_best_time = best_q;
  assign bus.o_live_time = live;
endmodule

// File: tb/tb_reaction_timer_multi.sv
// tb_reaction_timer_multi: directed and random rounds checked against a ms-level behavioural model
module tb_reaction_timer_multi;
  localparam int DVSR = 4, NP = 2, MIN = 3, RL = 2, TMO = 20;
  localparam int TMO_CYC = TMO * DVSR;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  reaction_timer_multi_if #(.N_PLAYERS(NP)) bus();
  reaction_timer_multi #(.DVSR(DVSR), .N_PLAYERS(NP), .MIN_DELAY_MS(MIN), .DELAY_RANGE_LOG2(RL), .TIMEOUT_MS(TMO)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int mode [NP];
  int cyc [NP];
  int hold [NP];
  logic [15:0] best_m = 16'h9999;
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= (m_lfsr >> 1) | 16'((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive_stops(input int phase, input int k);
    for (int p = 0; p < NP; p++) begin
      if (mode[p] == phase && cyc[p] == k) hold[p] = 3;
      bus.i_stop[p] = hold[p] > 0;
      if (hold[p] > 0) hold[p]--;
    end
  endtask
  // mode 0: never stops, 1: stops at WAIT cycle cyc, 2: stops at REACT cycle cyc; each stop is held 3 cycles
  task automatic run_round();
    int d, w, r, last_e, exp_r, res_t, wt;
    bit all_early, found;
    logic [2*NP-1:0] exp_res;
    logic [16*NP-1:0] exp_time;
    logic [1:0] wi;
    d = MIN + int'(m_lfsr & 16'd3);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("enter_wait", 32'(bus.o_state), 32'd1);
    all_early = 1'b1;
    last_e = 0;
    exp_r = 0;
    for (int p = 0; p < NP; p++) begin
      if (mode[p] == 1) last_e = cyc[p] > last_e ? cyc[p] : last_e;
      else begin
        all_early = 1'b0;
        res_t = (mode[p] == 2 && cyc[p] <= TMO_CYC) ? cyc[p] : TMO_CYC;
        exp_r = res_t + 1 > exp_r ? res_t + 1 : exp_r;
      end
    end
    w = 0;
    while (bus.o_state == 2'd1 && w < 300) begin
      chk("wait_stim", 32'(bus.o_stimulus), 32'd0);
      drive_stops(1, w);
      w++;
      @(negedge clk);
    end
    chk("wait_len", 32'(w), all_early ? 32'(last_e + 1) : 32'((d + 1) * DVSR));
    if (!all_early) begin
      chk("react_entry", 32'(bus.o_state), 32'd2);
      r = 0;
      while (bus.o_state == 2'd2 && r < 300) begin
        chk("react_stim", 32'(bus.o_stimulus), 32'd1);
        chk("live", 32'(bus.o_live_time), 32'(bcd(r / DVSR)));
        drive_stops(2, r);
        r++;
        @(negedge clk);
      end
      chk("react_len", 32'(r), 32'(exp_r));
    end
    chk("done_entry", 32'(bus.o_state), 32'd3);
    chk("done_stim", 32'(bus.o_stimulus), 32'd0);
    drive_stops(9, 0);
    @(negedge clk);
    found = 1'b0;
    wi = 2'd0;
    wt = 0;
    for (int p = 0; p < NP; p++) begin
      if (mode[p] == 1) begin
        exp_res[2*p +: 2] = 2'd2;
        exp_time[16*p +: 16] = 16'h9999;
      end else if (mode[p] == 2 && cyc[p] <= TMO_CYC) begin
        exp_res[2*p +: 2] = 2'd1;
        exp_time[16*p +: 16] = bcd(cyc[p] / DVSR);
        if (!found || cyc[p] / DVSR < wt) begin
          found = 1'b1;
          wi = 2'(p);
          wt = cyc[p] / DVSR;
        end
      end else begin
        exp_res[2*p +: 2] = 2'd3;
        exp_time[16*p +: 16] = bcd(TMO);
      end
    end
    if (found && bcd(wt) < best_m) best_m = bcd(wt);
    chk("results", 32'(bus.o_result), 32'(exp_res));
    chk("times", bus.o_time, exp_time);
    chk("winner_valid", 32'(bus.o_winner_valid), 32'(found));
    if (found) chk("winner", 32'(bus.o_winner), 32'(wi));
    chk("best", 32'(bus.o_best_time), 32'(best_m));
    chk("done_hold", 32'(bus.o_state), 32'd3);
    repeat (3) begin
      drive_stops(9, 0);
      @(negedge clk);
    end
    bus.i_stop = '0;
  endtask
  initial begin
    int n;
    bus.i_start = 1'b0;
    bus.i_stop = '0;
    for (int p = 0; p < NP; p++) hold[p] = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_best", 32'(bus.o_best_time), 32'h9999);
    chk("rst_result", 32'(bus.o_result), 32'd0);
    chk("rst_time", bus.o_time, 32'd0);
    chk("rst_valid", 32'(bus.o_winner_valid), 32'd0);
    chk("rst_live", 32'(bus.o_live_time), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mode = '{2, 2};
    cyc = '{28, 48};
    run_round();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    n = 0;
    while (bus.o_state != 2'd2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("reach_react", 32'(bus.o_state), 32'd2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.o_state), 32'd0);
    @(negedge clk);
    chk("arst_state2", 32'(bus.o_state), 32'd0);
    chk("arst_stim", 32'(bus.o_stimulus), 32'd0);
    chk("arst_best", 32'(bus.o_best_time), 32'h9999);
    chk("arst_result", 32'(bus.o_result), 32'd0);
    rst_n = 1'b1;
    best_m = 16'h9999;
    @(negedge clk);
    mode = '{2, 1};
    cyc = '{20, 5};
    run_round();
    mode = '{0, 0};
    cyc = '{0, 0};
    run_round();
    mode = '{1, 1};
    cyc = '{2, 7};
    run_round();
    mode = '{2, 2};
    cyc = '{36, 36};
    run_round();
    bus.i_stop = 2'b11;
    repeat (2) @(negedge clk);
    bus.i_stop = 2'b00;
    @(negedge clk);
    chk("done_ign_state", 32'(bus.o_state), 32'd3);
    chk("done_ign_result", 32'(bus.o_result), 32'b0101);
    chk("done_ign_time", bus.o_time, 32'h0009_0009);
    for (int k = 0; k < 12; k++) begin
      for (int p = 0; p < NP; p++) begin
        mode[p] = int'($urandom_range(0, 2));
        cyc[p] = mode[p] == 1 ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 90));
      end
      run_round();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
